// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, default widths and the add-3 correction threshold.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned InWDefault    = 16;
    localparam int unsigned DigitsDefault = 5;

    // A digit at or above this value is corrected by +3 before the shift.
    localparam int unsigned Add3Thresh = 5;

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble digit correction: passes a BCD digit through, adding 3 when it is >= 5.
// Ports:
//   digit_i  4-bit BCD scratch digit (0..9 in normal operation)
//   digit_o  corrected digit; never overflows 4 bits for inputs 0..9
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'(Add3Thresh)) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// A start accepted in idle captures bin_i; IN_W iterations later the result is loaded
// into bcd_o with a one-cycle done_o pulse. bcd_o/ovf4_o hold between conversions.
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    asynchronous active-high reset
//   start_i  conversion request, sampled only while idle
//   bin_i    unsigned binary input, captured on the accepting edge
//   busy_o   high whenever the converter is not idle
//   done_o   one-cycle pulse when a new result is loaded
//   bcd_o    packed BCD result, digit 0 (units) in bits [3:0]
//   ovf4_o   result exceeds 9999 (any digit at index >= 4 nonzero)
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned IN_W   = InWDefault,
    parameter int unsigned DIGITS = DigitsDefault
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [IN_W-1:0]       bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  ovf4_o
);

    localparam int unsigned CntW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int unsigned SW   = 4 * DIGITS;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [IN_W-1:0] shift_q, shift_d;
    logic [SW-1:0]   scratch_q, scratch_d;
    logic [SW-1:0]   scratch_adj;
    logic [SW-1:0]   bcd_q, bcd_d;
    logic            ovf4_q, ovf4_d;
    logic            done_q, done_d;
    logic            ovf4_calc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (scratch_adj[4*g +: 4])
        );
    end

    if (DIGITS > 4) begin : g_ovf
        assign ovf4_calc = |scratch_q[SW-1:16];
    end else begin : g_no_ovf
        assign ovf4_calc = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        ovf4_d    = ovf4_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    shift_d   = bin_i;
                    scratch_d = '0;
                    count_d   = '0;
                    state_d   = StConv;
                end
            end
            StConv: begin
                // Correct first, then shift the MSB of the binary into the BCD scratch.
                {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
                count_d = count_q + CntW'(1);
                if (count_q == CntW'(IN_W - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bcd_d   = scratch_q;
                ovf4_d  = ovf4_calc;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            count_q   <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            ovf4_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            ovf4_q    <= ovf4_d;
            done_q    <= done_d;
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;
    assign bcd_o  = bcd_q;
    assign ovf4_o = ovf4_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] bin_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [19:0] bcd_o;
    logic        ovf4_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [19:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    always #5 clk_i = ~clk_i;

    bin_to_bcd_seq dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .bin_i   (bin_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bcd_o   (bcd_o),
        .ovf4_o  (ovf4_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference by repeated division, independent of double dabble.
    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One conversion from an idle converter. glitch_k > 0 changes bin and pulses
    // start so that it is sampled at edge E+glitch_k.
    task automatic run_one(input logic [15:0] v, input logic [19:0] eb, input logic eo,
                           input int glitch_k);
        exp_t e;
        exp_t got;
        int   busy_cnt;
        int   done_cnt;
        int   done_k;
        bin_i   = v;
        start_i = 1'b1;
        e.bcd = eb;
        e.ovf = eo;
        sb_q.push_back(e);
        step();
        start_i  = 1'b0;
        busy_cnt = busy_o ? 1 : 0;
        done_cnt = 0;
        done_k   = 0;
        for (int k = 1; k <= 19; k++) begin
            if (k == glitch_k) begin
                bin_i   = 16'd1;
                start_i = 1'b1;
            end
            step();
            if (k == glitch_k) start_i = 1'b0;
            if (busy_o) busy_cnt++;
            if (done_o) begin
                done_cnt++;
                done_k = k;
                check("busy_low_in_done", 32'(busy_o), 32'd0);
                if (sb_q.size() > 0) begin
                    got = sb_q.pop_front();
                    check("bcd", 32'(bcd_o), 32'(got.bcd));
                    check("ovf4", 32'(ovf4_o), 32'(got.ovf));
                end else begin
                    check("unexpected_done", 32'd1, 32'd0);
                end
            end
        end
        check("busy_cycles", 32'(busy_cnt), 32'd17);
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_edge", 32'(done_k), 32'd17);
        check("bcd_hold", 32'(bcd_o), 32'(eb));
        if (sb_q.size() > 0) begin
            check("missing_result", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    initial begin
        int   done_cnt;
        int   busy_bad;
        int   last_done;
        int   gap_bad;
        logic [15:0] r;

        vecs[0] = '{bin: 16'd0,     bcd: 20'h00000, ovf: 1'b0};
        vecs[1] = '{bin: 16'd225,   bcd: 20'h00225, ovf: 1'b0};
        vecs[2] = '{bin: 16'd9999,  bcd: 20'h09999, ovf: 1'b0};
        vecs[3] = '{bin: 16'd10000, bcd: 20'h10000, ovf: 1'b1};
        vecs[4] = '{bin: 16'd65535, bcd: 20'h65535, ovf: 1'b1};
        vecs[5] = '{bin: 16'd1234,  bcd: 20'h01234, ovf: 1'b0};
        vecs[6] = '{bin: 16'd10,    bcd: 20'h00010, ovf: 1'b0};
        vecs[7] = '{bin: 16'd4095,  bcd: 20'h04095, ovf: 1'b0};
        vecs[8] = '{bin: 16'd59999, bcd: 20'h59999, ovf: 1'b1};
        vecs[9] = '{bin: 16'd32768, bcd: 20'h32768, ovf: 1'b1};

        // Reset state
        #12;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_bcd", 32'(bcd_o), 32'd0);
        check("rst_ovf4", 32'(ovf4_o), 32'd0);
        rst_i = 1'b0;
        step();

        foreach (vecs[i]) run_one(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, 0);

        for (int i = 0; i < 4; i++) begin
            r = 16'($urandom_range(0, 65535));
            run_one(r, to_bcd(int'(r)), (r > 16'd9999), 0);
        end

        // Mid-conversion bin change and start pulse at E+5 are ignored
        run_one(16'd65535, 20'h65535, 1'b1, 5);

        // Reset abort mid-conversion
        run_one(16'd1234, 20'h01234, 1'b0, 0);
        bin_i   = 16'd4321;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 1; k <= 7; k++) step();
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_bcd", 32'(bcd_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        step();
        rst_i = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done_o) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_one(16'd42, 20'h00042, 1'b0, 0);

        // start held high: one result every 18 cycles, busy low only in done cycles
        bin_i   = 16'd7;
        start_i = 1'b1;
        step();
        done_cnt  = 0;
        busy_bad  = 0;
        gap_bad   = 0;
        last_done = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (busy_o == done_o) busy_bad++;
            if (done_o) begin
                if (done_cnt == 0) begin
                    if (k != 17) gap_bad++;
                end else if (k - last_done != 18) begin
                    gap_bad++;
                end
                done_cnt++;
                last_done = k;
                check("held_bcd", 32'(bcd_o), 32'h00007);
            end
        end
        start_i = 1'b0;
        check("held_done_count", 32'(done_cnt), 32'd3);
        check("held_period", 32'(gap_bad), 32'd0);
        check("held_busy_vs_done", 32'(busy_bad), 32'd0);
        for (int k = 0; k < 20; k++) step();
        check("final_idle", 32'(busy_o), 32'd0);
        check("final_bcd", 32'(bcd_o), 32'h00007);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits between the multiplier's 16-bit product and the per-digit 7-segment decoders. The display path then shows the product in decimal instead of hex. A start/busy/done handshake lets the multiplier launch a conversion whenever its result changes. The last valid result is held stable for the display updater.

## Interface
- IN_W, 16, width of the binary input.
- DIGITS, 5, number of BCD digits produced.
  - Must satisfy 10^DIGITS > 2^IN_W − 1.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  conversion request; sampled only in IDLE.
- bin  in  IN_W  unsigned binary value; captured on the accepting edge.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  single-cycle pulse when a new result is loaded into bcd.
- bcd  out  4*DIGITS  result; digit 0 is bits [3:0] (units), packed upward.
- ovf4  out  1  result exceeds 9999, i.e. any digit at index ≥4 is nonzero.
  - Registered together with bcd; tied 0 if DIGITS ≤ 4.

## Operation
- States: IDLE, CONV, DONE.
- IDLE:
  - start=1 → load bin into shift register, clear BCD scratch, count ← 0, go to CONV.
  - start=0 → stay in IDLE.
- CONV, each cycle:
  - For every scratch digit ≥5, add 3 (4-bit; digits never exceed 9 before correction, so no carry out).
  - Then shift {scratch, shift_reg} left by 1 and increment count.
  - When count == IN_W−1 at the edge, go to DONE after performing that iteration.
- DONE: bcd ← scratch, ovf4 ← OR of scratch digits ≥ index 4, done ← 1, go to IDLE.
- bcd and ovf4 change only on the DONE edge and otherwise hold their value.
- start in CONV or DONE is ignored; no queuing.
- Changes to bin after the accepting edge have no effect on the conversion in flight.
- Unsigned arithmetic only; no rounding or saturation.

## Timing
- Reset values: state IDLE, busy 0, done 0, bcd all zero, ovf4 0, scratch/shift/count 0.
- Reset is asynchronous and takes effect immediately, including mid-conversion.
  - A conversion in flight is aborted, no done is produced, and bcd returns to 0.
- Cycle numbering: start accepted at edge E.
  - Edges E+1 … E+IN_W perform the IN_W iterations.
  - Edge E+IN_W+1 loads bcd and raises done.
  - done is high for exactly one cycle and is low again after edge E+IN_W+2.
- Latency is IN_W+1 cycles from the accepting edge to bcd valid (17 for IN_W=16).
- busy is high from after edge E until edge E+IN_W+1, and low in the cycle where done is high.
- Earliest next accept is edge E+IN_W+2, giving a throughput of one conversion per IN_W+2 cycles (18).
- If start is held high continuously, conversions repeat at that period, each using the current bin.
- start asserted in the same cycle that done is high is accepted; busy is low there.

## Structure
- Shared package/header holds:
  - State encoding constants (IDLE, CONV, DONE).
  - Defaults IN_W=16, DIGITS=5.
  - The add-3 threshold constant (5).
- One sub-module, bcd_add3: 4-bit combinational digit correction (d ≥ 5 ? d+3 : d).
  - Instantiated DIGITS times in a generate loop.
- count width is clog2(IN_W).
- The top-level display module instantiates this block between the multiplier output and the digit decoders.
  - The multiplier drives start from a product-changed strobe.

## Test plan
- Reset, then bin=0 and a one-cycle start:
  - busy high for 17 cycles.
  - done pulses at edge E+17.
  - bcd=0x00000, ovf4=0.
- bin=225: bcd=0x00225, ovf4=0.
- bin=9999 → bcd=0x09999, ovf4=0; then bin=10000 → bcd=0x10000, ovf4=1.
- bin=65535:
  - bcd=0x65535, ovf4=1.
  - Change bin to 1 and pulse start at E+5: both ignored; result is still 0x65535.
  - Exactly one done pulse.
- Complete a conversion of 1234, then convert 4321 and assert rst at E+8:
  - busy 0 immediately, bcd=0, no done pulse.
  - A new start with bin=42 yields bcd=0x00042.
- start held high with bin=7:
  - done pulses every 18 cycles, bcd stays 0x00007.
  - busy is low exactly in each done cycle.
